laser_host: RTL and testbench

Host-side driver and scorer for the LASER two-circle coverage core. It holds a 40-entry target memory loaded over a simple write port and releases the core from reset. It then streams the targets on the core's X/Y inputs one per cycle, waits for DONE and captures the two circle centres. Finally it rescores the result against the stored targets and reports the covered-target count, so the core can be exercised and self-checked in-system.

---
 rtl/laser_host.sv | 219 +++++++++++++++++++++
 tb/tb_laser_host.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_host.sv
`default_nettype none
// ============================================================================
// Module   : laser_host
// Brief    : Loads targets, streams them to the LASER core, captures its two
//            circle centres and rescores them against the stored targets.
// Revision : 1.0
// ============================================================================
module laser_host #(
    parameter int N_TGT     = 40,
    parameter int RADIUS_SQ = 16,
    parameter int TIMEOUT   = 40000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic       start,
    output logic       busy,
    output logic       core_rst,
    output logic [3:0] X,
    output logic [3:0] Y,
    input  logic       DONE,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    output logic [3:0] res_c1x,
    output logic [3:0] res_c1y,
    output logic [3:0] res_c2x,
    output logic [3:0] res_c2y,
    output logic [5:0] cover_cnt,
    output logic       timeout,
    output logic       result_valid
);

    localparam logic [5:0]  C_IDX_LAST = 6'(N_TGT - 1);
    localparam logic [5:0]  C_N_TGT    = 6'(N_TGT);
    localparam logic [15:0] C_WAIT_MAX = 16'(TIMEOUT - 1);
    localparam logic [8:0]  C_RAD_SQ   = 9'(RADIUS_SQ);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND   = 3'd1,
        S_WAIT   = 3'd2,
        S_SCORE  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_idx;
    logic [15:0] r_wcnt;
    logic [3:0]  r_mem_x [N_TGT];
    logic [3:0]  r_mem_y [N_TGT];
    logic [3:0]  r_x, r_y;
    logic [3:0]  r_c1x, r_c1y, r_c2x, r_c2y;
    logic [5:0]  r_cover;
    logic        r_timeout, r_valid, r_busy, r_core_rst;

    logic        w_last;
    logic        w_expired;
    logic        w_mem_we;
    logic [5:0]  w_rd_idx;
    logic [3:0]  w_rd_x, w_rd_y;
    logic        w_hit;

    function automatic logic f_covered(input logic [3:0] cx, input logic [3:0] cy,
                                       input logic [3:0] px, input logic [3:0] py);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] sx;
        logic [7:0] sy;
        logic [8:0] s;
        dx = (cx >= px) ? (cx - px) : (px - cx);
        dy = (cy >= py) ? (cy - py) : (py - cy);
        sx = {4'd0, dx} * {4'd0, dx};
        sy = {4'd0, dy} * {4'd0, dy};
        s  = {1'b0, sx} + {1'b0, sy};
        return (s <= C_RAD_SQ);
    endfunction

    assign w_last    = (r_idx == C_IDX_LAST);
    assign w_expired = (r_wcnt == C_WAIT_MAX);
    assign w_mem_we  = wr_en && (r_state == S_IDLE) && (wr_addr < C_N_TGT);

    // Index of the entry needed at the next edge (stream) or in this cycle (score)
    always_comb begin
        w_rd_idx = 6'd0;
        case (r_state)
            S_SEND:  w_rd_idx = w_last ? 6'd0 : (r_idx + 6'd1);
            S_SCORE: w_rd_idx = r_idx;
            default: w_rd_idx = 6'd0;
        endcase
    end

    // A write landing in the start cycle must be the value streamed
    always_comb begin
        w_rd_x = r_mem_x[w_rd_idx];
        w_rd_y = r_mem_y[w_rd_idx];
        if (w_mem_we && (wr_addr == w_rd_idx)) begin
            w_rd_x = wr_x;
            w_rd_y = wr_y;
        end
    end

    assign w_hit = f_covered(r_c1x, r_c1y, w_rd_x, w_rd_y) ||
                   f_covered(r_c2x, r_c2y, w_rd_x, w_rd_y);

    // Target memory is deliberately outside the reset domain
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem_x[wr_addr] <= wr_x;
            r_mem_y[wr_addr] <= wr_y;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SEND;
            S_SEND:   if (w_last) w_next = S_WAIT;
            S_WAIT: begin
                if (DONE)           w_next = S_SCORE;
                else if (w_expired) w_next = S_REPORT;
            end
            S_SCORE:  if (w_last) w_next = S_REPORT;
            S_REPORT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idx      <= 6'd0;
            r_wcnt     <= 16'd0;
            r_x        <= 4'd0;
            r_y        <= 4'd0;
            r_c1x      <= 4'd0;
            r_c1y      <= 4'd0;
            r_c2x      <= 4'd0;
            r_c2y      <= 4'd0;
            r_cover    <= 6'd0;
            r_timeout  <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_core_rst <= 1'b1;
        end else begin
            r_busy     <= (w_next != S_IDLE);
            r_core_rst <= !((w_next == S_SEND) || (w_next == S_WAIT));
            r_valid    <= (w_next == S_REPORT);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx <= 6'd0;
                        r_x   <= w_rd_x;
                        r_y   <= w_rd_y;
                    end
                end
                S_SEND: begin
                    if (w_last) begin
                        r_x    <= 4'd0;
                        r_y    <= 4'd0;
                        r_wcnt <= 16'd0;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                        r_x   <= w_rd_x;
                        r_y   <= w_rd_y;
                    end
                end
                S_WAIT: begin
                    if (DONE) begin
                        r_c1x     <= C1X;
                        r_c1y     <= C1Y;
                        r_c2x     <= C2X;
                        r_c2y     <= C2Y;
                        r_timeout <= 1'b0;
                        r_idx     <= 6'd0;
                        r_cover   <= 6'd0;
                    end else if (w_expired) begin
                        r_c1x     <= 4'd0;
                        r_c1y     <= 4'd0;
                        r_c2x     <= 4'd0;
                        r_c2y     <= 4'd0;
                        r_timeout <= 1'b1;
                        r_cover   <= 6'd0;
                    end else begin
                        r_wcnt <= r_wcnt + 16'd1;
                    end
                end
                S_SCORE: begin
                    r_cover <= r_cover + {5'd0, w_hit};
                    r_idx   <= r_idx + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy         = r_busy;
    assign core_rst     = r_core_rst;
    assign X            = r_x;
    assign Y            = r_y;
    assign res_c1x      = r_c1x;
    assign res_c1y      = r_c1y;
    assign res_c2x      = r_c2x;
    assign res_c2y      = r_c2y;
    assign cover_cnt    = r_cover;
    assign timeout      = r_timeout;
    assign result_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_laser_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_laser_host
// Brief    : Self-checking bench for laser_host with a behavioural core/scorer.
// Revision : 1.0
// ============================================================================
module tb_laser_host;

    localparam int N   = 40;
    localparam int TMO = 100;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [3:0] wr_x = '0, wr_y = '0;
    logic       start = 1'b0;
    logic       busy, core_rst, timeout, result_valid;
    logic [3:0] X, Y;
    logic       DONE = 1'b0;
    logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
    logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
    logic [5:0] cover_cnt;

    int checks   = 0;
    int failures = 0;
    int ref_x [N];
    int ref_y [N];

    typedef struct {
        int pat;
        int c1x, c1y, c2x, c2y;
        int w;
        bit poke;
        int exp_cnt;
    } vec_t;

    always #5 CLK = ~CLK;

    laser_host #(.N_TGT(N), .RADIUS_SQ(16), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
        .start(start), .busy(busy), .core_rst(core_rst), .X(X), .Y(Y),
        .DONE(DONE), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
        .cover_cnt(cover_cnt), .timeout(timeout), .result_valid(result_valid)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input int x, input int y);
        logic [5:0] av;
        av      = 6'(a);
        wr_en   = 1'b1;
        wr_addr = av;
        wr_x    = 4'(x);
        wr_y    = 4'(y);
        tick();
        wr_en = 1'b0;
        if (a < N) begin
            ref_x[a] = x;
            ref_y[a] = y;
        end
    endtask

    task automatic load(input int pat);
        for (int i = 0; i < N; i++) begin
            case (pat)
                0: wr(i, 5, 5);
                1: wr(i, i % 16, i / 16);
                2: begin
                    case (i)
                        0:       wr(i, 4, 0);
                        1:       wr(i, 2, 3);
                        2:       wr(i, 3, 3);
                        3:       wr(i, 4, 1);
                        default: wr(i, 8, 8);
                    endcase
                end
                default: wr(i, $urandom_range(0, 15), $urandom_range(0, 15));
            endcase
        end
        // out-of-range addresses must not disturb anything
        if (pat == 3) begin
            for (int i = 0; i < 4; i++) wr($urandom_range(N, 63), $urandom_range(0, 15), $urandom_range(0, 15));
        end
    endtask

    function automatic int model_cnt(input int c1x, input int c1y, input int c2x, input int c2y);
        int n = 0;
        for (int i = 0; i < N; i++) begin
            int d1 = (ref_x[i] - c1x) * (ref_x[i] - c1x) + (ref_y[i] - c1y) * (ref_y[i] - c1y);
            int d2 = (ref_x[i] - c2x) * (ref_x[i] - c2x) + (ref_y[i] - c2y) * (ref_y[i] - c2y);
            if (d1 <= 16 || d2 <= 16) n++;
        end
        return n;
    endfunction

    // w = WAIT cycles before DONE is sampled (w<1: DONE never asserted)
    task automatic run(input int c1x, input int c1y, input int c2x, input int c2y,
                       input int w, input bit poke, input bit wr_with_start, input int exp_in);
        int exp_cnt;
        int nx, ny;
        C1X = 4'(c1x); C1Y = 4'(c1y); C2X = 4'(c2x); C2Y = 4'(c2y);
        nx = $urandom_range(0, 15);
        ny = $urandom_range(0, 15);
        if (wr_with_start) begin
            wr_en = 1'b1; wr_addr = 6'd0; wr_x = 4'(nx); wr_y = 4'(ny);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        if (wr_with_start) begin
            ref_x[0] = nx;
            ref_y[0] = ny;
        end
        exp_cnt = (w < 1) ? 0 : ((exp_in < 0) ? model_cnt(c1x, c1y, c2x, c2y) : exp_in);
        chk("send_core_rst", core_rst, 0);
        chk("send_busy", busy, 1);
        for (int k = 0; k < N; k++) begin
            if (k > 0) tick();
            chk($sformatf("stream_x[%0d]", k), X, ref_x[k]);
            chk($sformatf("stream_y[%0d]", k), Y, ref_y[k]);
            chk("stream_core_rst", core_rst, 0);
        end
        tick();
        chk("wait_x", X, 0);
        chk("wait_y", Y, 0);
        chk("wait_core_rst", core_rst, 0);
        for (int c = 1; c <= TMO; c++) begin
            if (c == w) DONE = 1'b1;
            if (poke && c == 1) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 6'd0; wr_x = 4'd15; wr_y = 4'd15;
            end
            tick();
            DONE = 1'b0; start = 1'b0; wr_en = 1'b0;
            if (c == w) break;
            if (c < TMO) chk("wait_no_valid", result_valid, 0);
        end
        if (w >= 1) begin
            chk("score_core_rst", core_rst, 1);
            chk("score_no_valid", result_valid, 0);
            for (int s = 1; s < N; s++) begin
                tick();
                chk("score_no_valid", result_valid, 0);
            end
            tick();
        end
        chk("report_valid", result_valid, 1);
        chk("report_timeout", timeout, (w < 1) ? 1 : 0);
        chk("report_cover", cover_cnt, exp_cnt);
        chk("report_c1x", res_c1x, (w < 1) ? 0 : c1x);
        chk("report_c1y", res_c1y, (w < 1) ? 0 : c1y);
        chk("report_c2x", res_c2x, (w < 1) ? 0 : c2x);
        chk("report_c2y", res_c2y, (w < 1) ? 0 : c2y);
        chk("report_core_rst", core_rst, 1);
        tick();
        chk("idle_valid", result_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_core_rst", core_rst, 1);
        chk("idle_cover_hold", cover_cnt, exp_cnt);
    endtask

    task automatic reset_mid_send();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) tick();
        chk("pre_rst_x20", X, ref_x[20]);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_core_rst", core_rst, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_x", X, 0);
        chk("mid_rst_valid", result_valid, 0);
        tick();
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_valid", result_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        tbl[0] = '{pat: 0, c1x: 5, c1y: 5, c2x: 12, c2y: 12, w: 3,   poke: 1'b0, exp_cnt: 40};
        tbl[1] = '{pat: 1, c1x: 0, c1y: 0, c2x: 15, c2y: 15, w: 1,   poke: 1'b0, exp_cnt: 13};
        tbl[2] = '{pat: 2, c1x: 0, c1y: 0, c2x: 15, c2y: 15, w: 5,   poke: 1'b0, exp_cnt: 2};
        tbl[3] = '{pat: 2, c1x: 0, c1y: 0, c2x: 15, c2y: 15, w: 0,   poke: 1'b0, exp_cnt: 0};
        tbl[4] = '{pat: 2, c1x: 0, c1y: 0, c2x: 15, c2y: 15, w: 7,   poke: 1'b1, exp_cnt: 2};
        tbl[5] = '{pat: 2, c1x: 0, c1y: 0, c2x: 15, c2y: 15, w: TMO, poke: 1'b0, exp_cnt: 2};

        tick();
        tick();
        chk("rst_core_rst", core_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_x", X, 0);
        chk("rst_y", Y, 0);
        chk("rst_cover", cover_cnt, 0);
        chk("rst_res", {res_c1x, res_c1y, res_c2x, res_c2y}, 0);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            if (i == 0 || tbl[i].pat != tbl[i-1].pat) load(tbl[i].pat);
            run(tbl[i].c1x, tbl[i].c1y, tbl[i].c2x, tbl[i].c2y, tbl[i].w, tbl[i].poke, 1'b0, tbl[i].exp_cnt);
        end

        load(1);
        reset_mid_send();
        run(3, 1, 10, 2, 4, 1'b0, 1'b0, -1);

        for (int r = 0; r < 8; r++) begin
            if (r % 2 == 0) load(3);
            run($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(1, TMO), 1'b0, 1'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
